// File: rtl/arb_pkg.sv
// Shared types and helpers for the warp round-robin arbiter.
package arb_pkg;

  localparam int ARB_DEFAULT_WIDTH    = 8;
  localparam int ARB_DEFAULT_MAX_LOCK = 4;

  // Widest requester vector the index helper understands.
  localparam int ARB_MAX_W = 64;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Binary index of a one-hot vector (zero-extend narrower vectors to ARB_MAX_W).
  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Rotating barrel shifter: rotates data by (amt + OFF) mod WIDTH,
// to the right (LEFT=0) or to the left (LEFT=1).
module barrel_shifter #(
  parameter int WIDTH = 8,
  parameter int OFF   = 0,
  parameter bit LEFT  = 1'b0
) (
  input  logic [WIDTH-1:0]         data_i,
  input  logic [$clog2(WIDTH)-1:0] amt_i,
  output logic [WIDTH-1:0]         data_o
);

  int sh;

  // Rotate by the effective shift amount, wrapping at WIDTH.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    data_o = '0;
    sh     = (int'(amt_i) + OFF) % WIDTH;
    for (int i = 0; i < WIDTH; i++) begin
      if (LEFT) data_o[(i + sh) % WIDTH] = data_i[i];
      else      data_o[i]                = data_i[(i + sh) % WIDTH];
    end
  end

endmodule

// File: rtl/warp_rr_arbiter.sv
// Round-robin arbiter sharing one issue slot among WIDTH warp requesters.
// Registered one-hot grant with valid/ready handshake; search starts just
// past the last winner held in a one-hot pointer.
// Optional feature macro ARB_LOCK_EN: a requester holding lock may keep the
// grant for up to MAX_LOCK consecutive handshakes.
module warp_rr_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = ARB_DEFAULT_WIDTH,
  parameter int MAX_LOCK = ARB_DEFAULT_MAX_LOCK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         mask,
  input  logic [WIDTH-1:0]         lock,
  input  logic                     grant_ready,
  output logic                     grant_valid,
  output logic [WIDTH-1:0]         grant,
  output logic [$clog2(WIDTH)-1:0] grant_id
);

  localparam int ID_W = $clog2(WIDTH);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             grant_valid_q, grant_valid_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] eligible;
  logic             handshake;
  logic [WIDTH-1:0] ptr_search;
  logic [ID_W-1:0]  search_idx;
  logic [WIDTH-1:0] rot_elig;
  logic [WIDTH-1:0] rot_pick;
  logic [WIDTH-1:0] winner;
  logic [WIDTH-1:0] next_grant;

  assign eligible  = req & ~mask;
  assign handshake = grant_valid_q & grant_ready;

  // On a handshake the search must already use the updated pointer (= current grant).
  assign ptr_search = handshake ? grant_q : ptr_q;
  assign search_idx = ID_W'(onehot_to_idx(ARB_MAX_W'(ptr_search)));

  // Bring the bit just past the last winner down to position 0.
  barrel_shifter #(.WIDTH(WIDTH), .OFF(1), .LEFT(1'b0)) u_rot_right (
    .data_i (eligible),
    .amt_i  (search_idx),
    .data_o (rot_elig)
  );

  // Lowest set bit in rotated space is the first eligible requester in search order.
  assign rot_pick = rot_elig & (-rot_elig);

  // Undo the rotation to get the winner in requester space.
  barrel_shifter #(.WIDTH(WIDTH), .OFF(1), .LEFT(1'b1)) u_rot_left (
    .data_i (rot_pick),
    .amt_i  (search_idx),
    .data_o (winner)
  );

`ifdef ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
  logic unused_lock;
  assign unused_lock = ^{lock, MAX_LOCK[0]};
`endif

  // Next-state, next-grant and pointer computation.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    next_grant    = winner;
`ifdef ARB_LOCK_EN
    lock_cnt_d    = lock_cnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
`ifdef ARB_LOCK_EN
        lock_cnt_d = '0;
`endif
        if (|winner) begin
          grant_d       = winner;
          grant_id_d    = ID_W'(onehot_to_idx(ARB_MAX_W'(winner)));
          grant_valid_d = 1'b1;
          state_d       = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (handshake) begin
          ptr_d = grant_q;
`ifdef ARB_LOCK_EN
          // Re-grant a locked requester without advancing the pointer, up to MAX_LOCK handshakes.
          if (lock[grant_id_q] && eligible[grant_id_q] &&
              (lock_cnt_q < CNT_W'(MAX_LOCK - 1))) begin
            ptr_d      = ptr_q;
            next_grant = grant_q;
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_d = '0;
          end
`endif
          if (|next_grant) begin
            grant_d    = next_grant;
            grant_id_d = ID_W'(onehot_to_idx(ARB_MAX_W'(next_grant)));
          end else begin
            grant_d       = '0;
            grant_id_d    = '0;
            grant_valid_d = 1'b0;
            state_d       = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // FSM state and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      // NOTE: the pointer is a control register and must be reset so index 0 has first priority.
      ptr_q         <= {1'b1, {(WIDTH-1){1'b0}}};
`ifdef ARB_LOCK_EN
      lock_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q    <= lock_cnt_d;
`endif
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;

endmodule
